// File: rtl/mii_chk_pkg.sv
// Purpose: shared control codes, FSM states and error codes for the MII frame checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mii_chk_pkg;

    // Control codes carried in lane0 when the word is flagged as control
    localparam logic [7:0] CODE_IDLE  = 8'h07;
    localparam logic [7:0] CODE_START = 8'hFB;
    localparam logic [7:0] CODE_TERM  = 8'hFD;
    localparam logic [7:0] CODE_ERR   = 8'hFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    // Numeric order doubles as report priority (lower non-zero wins)
    typedef enum logic [2:0] {
        ERR_OK     = 3'd0,
        ERR_CTRL   = 3'd1,
        ERR_NOTERM = 3'd2,
        ERR_LONG   = 3'd3,
        ERR_SHORT  = 3'd4,
        ERR_PAT    = 3'd5
    } err_t;

endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an increment request one clk after it is asserted.
// Backpressure: none; increments requested at saturation are dropped.
//
// Ports: clk, i_rst (sync, active-high), i_inc (increment request), o_count (current value).
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (i_inc && !(&o_count)) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mii_frame_checker.sv
// Purpose: delimits START..TERM frames on a 64-bit MII stream; checks length and incrementing-byte payload.
// Latency: per-frame result pulses one clk after the closing word is sampled.
// Backpressure: none; the stream is sampled every clk and cannot be stalled.
//
// Ports: clk, i_rst (sync, active-high); i_rx_data/i_rx_ctrl word stream in;
//        o_frame_valid pulse with o_frame_ok/o_err_code/o_frame_len held until the next report;
//        o_good_cnt/o_bad_cnt saturating frame counters.
module mii_frame_checker
    import mii_chk_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = 1,
    parameter int MIN_WORDS     = 8,
    parameter int MAX_WORDS     = 190,
    parameter int CHECK_PATTERN = 1,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic                  o_frame_valid,
    output logic                  o_frame_ok,
    output logic [2:0]            o_err_code,
    output logic [15:0]           o_frame_len,
    output logic [CNT_WIDTH-1:0]  o_good_cnt,
    output logic [CNT_WIDTH-1:0]  o_bad_cnt
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_WORDS);
    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  exp_q, exp_d;
    logic        pat_q, pat_d;

    logic        rep_vld;
    err_t        rep_err;
    logic [15:0] rep_len;

    logic [7:0]  lane_ok;
    logic        word_bad;
    logic        is_ctrl;
    logic [7:0]  code;

    assign is_ctrl = i_rx_ctrl[0];
    assign code    = i_rx_data[7:0];

    // Lane i of a payload word must carry exp+i (mod 256)
    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane_ok[i] = (i_rx_data[8*i +: 8] == (exp_q + 8'(i)));
    end

    assign word_bad = (CHECK_PATTERN != 0) && (lane_ok != 8'hFF);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        exp_d   = exp_q;
        pat_d   = pat_q;
        rep_vld = 1'b0;
        rep_err = ERR_OK;
        rep_len = len_q;

        case (state_q)
            IDLE: begin
                if (is_ctrl && code == CODE_START) begin
                    state_d = DATA;
                    len_d   = '0;
                    exp_d   = '0;
                    pat_d   = 1'b0;
                end
            end

            DATA: begin
                if (!is_ctrl) begin
                    if (len_q == MAX_LEN) begin
                        // Report the over-length word count now, then swallow the tail
                        rep_vld = 1'b1;
                        rep_err = ERR_LONG;
                        rep_len = len_q + 16'd1;
                        state_d = DROP;
                    end else begin
                        len_d = len_q + 16'd1;
                        exp_d = exp_q + 8'd8;
                        pat_d = pat_q | word_bad;
                    end
                end else begin
                    rep_vld = 1'b1;
                    case (code)
                        CODE_TERM: begin
                            rep_err = (len_q < MIN_LEN) ? ERR_SHORT :
                                      (pat_q ? ERR_PAT : ERR_OK);
                            state_d = IDLE;
                        end
                        CODE_START: begin
                            // Unterminated frame closes and a fresh one opens on this word
                            rep_err = ERR_NOTERM;
                            len_d   = '0;
                            exp_d   = '0;
                            pat_d   = 1'b0;
                        end
                        CODE_IDLE: begin
                            rep_err = ERR_NOTERM;
                            state_d = IDLE;
                        end
                        default: begin
                            rep_err = ERR_CTRL;
                            state_d = IDLE;
                        end
                    endcase
                end
            end

            DROP: begin
                if (is_ctrl) begin
                    if (code == CODE_START) begin
                        state_d = DATA;
                        len_d   = '0;
                        exp_d   = '0;
                        pat_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            exp_q         <= '0;
            pat_q         <= 1'b0;
            o_frame_valid <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_err_code    <= '0;
            o_frame_len   <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            exp_q         <= exp_d;
            pat_q         <= pat_d;
            o_frame_valid <= rep_vld;
            if (rep_vld) begin
                o_frame_ok  <= (rep_err == ERR_OK);
                o_err_code  <= rep_err;
                o_frame_len <= rep_len;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_good_cnt (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_inc   (rep_vld && (rep_err == ERR_OK)),
        .o_count (o_good_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bad_cnt (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_inc   (rep_vld && (rep_err != ERR_OK)),
        .o_count (o_bad_cnt)
    );

endmodule

// File: tb/tb_mii_frame_checker.sv
// Purpose: directed bench for mii_frame_checker; a pattern-checking and a pattern-blind instance share one stream.
// Latency: expected reports are queued with the closing word and must appear exactly one clk later.
// Backpressure: n/a.
module tb_mii_frame_checker;

    typedef struct {
        logic        ok;
        logic [2:0]  err;
        logic [15:0] len;
    } rep_t;

    logic        clk;
    logic        rst;
    logic [63:0] rx_data;
    logic [0:0]  rx_ctrl;

    logic        v0, ok0, v1, ok1;
    logic [2:0]  err0, err1;
    logic [15:0] len0, len1;
    logic [31:0] good0, bad0, good1, bad1;

    rep_t q0[$];
    rep_t q1[$];

    int vectors;
    int miscompares;

    mii_frame_checker #(.CHECK_PATTERN(1)) dut0 (
        .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
        .o_frame_valid(v0), .o_frame_ok(ok0), .o_err_code(err0), .o_frame_len(len0),
        .o_good_cnt(good0), .o_bad_cnt(bad0)
    );

    mii_frame_checker #(.CHECK_PATTERN(0)) dut1 (
        .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
        .o_frame_valid(v1), .o_frame_ok(ok1), .o_err_code(err1), .o_frame_len(len1),
        .o_good_cnt(good1), .o_bad_cnt(bad1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pw(input logic [7:0] b);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = b + 8'(i);
        return w;
    endfunction

    function automatic logic [63:0] cw(input logic [7:0] code);
        return {56'h07070707070707, code};
    endfunction

    function automatic rep_t mk(input logic ok, input logic [2:0] err, input logic [15:0] len);
        rep_t r;
        r.ok = ok; r.err = err; r.len = len;
        return r;
    endfunction

    // A pushed expectation must be matched by a pulse on the very next sample
    task automatic check_out();
        rep_t e;
        logic ev0, ev1;
        ev0 = (q0.size() != 0);
        ev1 = (q1.size() != 0);
        cmp("pulse0", {31'd0, v0}, {31'd0, ev0});
        cmp("pulse1", {31'd0, v1}, {31'd0, ev1});
        if (ev0) begin
            e = q0.pop_front();
            if (v0 === 1'b1) begin
                cmp("ok0",  {31'd0, ok0},  {31'd0, e.ok});
                cmp("err0", {29'd0, err0}, {29'd0, e.err});
                cmp("len0", {16'd0, len0}, {16'd0, e.len});
            end
        end
        if (ev1) begin
            e = q1.pop_front();
            if (v1 === 1'b1) begin
                cmp("ok1",  {31'd0, ok1},  {31'd0, e.ok});
                cmp("err1", {29'd0, err1}, {29'd0, e.err});
                cmp("len1", {16'd0, len1}, {16'd0, e.len});
            end
        end
    endtask

    task automatic step(input logic [63:0] d, input logic c);
        rx_data = d;
        rx_ctrl = c;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic words(input int n);
        for (int k = 0; k < n; k++) step(pw(8'(k * 8)), 1'b0);
    endtask

    task automatic expect_both(input rep_t r0, input rep_t r1);
        q0.push_back(r0);
        q1.push_back(r1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx_data     = cw(8'h07);
        rx_ctrl     = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        cmp("rst_valid", {31'd0, v0}, 32'd0);
        cmp("rst_ok",    {31'd0, ok0}, 32'd0);
        cmp("rst_err",   {29'd0, err0}, 32'd0);
        cmp("rst_len",   {16'd0, len0}, 32'd0);
        cmp("rst_good",  good0, 32'd0);
        cmp("rst_bad",   bad0, 32'd0);
        rst = 1'b0;
        step(cw(8'h07), 1'b1);

        // 1: minimum-length good frame
        step(cw(8'hFB), 1'b1);
        words(8);
        expect_both(mk(1'b1, 3'd0, 16'd8), mk(1'b1, 3'd0, 16'd8));
        step(cw(8'hFD), 1'b1);
        cmp("t1_good", good0, 32'd1);
        cmp("t1_bad",  bad0, 32'd0);

        // 2: one word short; back-to-back START right after previous TERM
        step(cw(8'hFB), 1'b1);
        words(7);
        expect_both(mk(1'b0, 3'd4, 16'd7), mk(1'b0, 3'd4, 16'd7));
        step(cw(8'hFD), 1'b1);
        cmp("t2_bad", bad0, 32'd1);

        // Exactly MAX_WORDS is still accepted
        step(cw(8'hFB), 1'b1);
        words(190);
        expect_both(mk(1'b1, 3'd0, 16'd190), mk(1'b1, 3'd0, 16'd190));
        step(cw(8'hFD), 1'b1);
        cmp("max_good", good0, 32'd2);

        // 3: over-length; report on word 191, tail and TERM are silent
        step(cw(8'hFB), 1'b1);
        words(190);
        expect_both(mk(1'b0, 3'd3, 16'd191), mk(1'b0, 3'd3, 16'd191));
        step(pw(8'hF0), 1'b0);
        words(3);
        step(cw(8'hFD), 1'b1);
        step(cw(8'h07), 1'b1);
        cmp("t3_bad", bad0, 32'd2);

        // 4: word 3 lane5 corrupted; only the pattern-checking instance flags it
        step(cw(8'hFB), 1'b1);
        for (int k = 0; k < 10; k++) begin
            logic [63:0] w;
            w = pw(8'(k * 8));
            if (k == 3) w[47:40] = 8'hFF;
            step(w, 1'b0);
        end
        expect_both(mk(1'b0, 3'd5, 16'd10), mk(1'b1, 3'd0, 16'd10));
        step(cw(8'hFD), 1'b1);
        cmp("t4_bad0",  bad0, 32'd3);
        cmp("t4_good1", good1, 32'd3);

        // 5: START inside a frame closes it as NOTERM and opens a new one
        step(cw(8'hFB), 1'b1);
        words(4);
        expect_both(mk(1'b0, 3'd2, 16'd4), mk(1'b0, 3'd2, 16'd4));
        step(cw(8'hFB), 1'b1);
        words(8);
        expect_both(mk(1'b1, 3'd0, 16'd8), mk(1'b1, 3'd0, 16'd8));
        step(cw(8'hFD), 1'b1);
        cmp("t5_good", good0, 32'd3);
        cmp("t5_bad",  bad0, 32'd4);

        // Unknown control code mid-frame is a CTRL error; IDLE mid-frame is NOTERM
        step(cw(8'hFB), 1'b1);
        words(2);
        expect_both(mk(1'b0, 3'd1, 16'd2), mk(1'b0, 3'd1, 16'd2));
        step(cw(8'h5A), 1'b1);
        step(cw(8'hFB), 1'b1);
        words(3);
        expect_both(mk(1'b0, 3'd2, 16'd3), mk(1'b0, 3'd2, 16'd3));
        step(cw(8'h07), 1'b1);
        cmp("ctl_bad", bad0, 32'd6);

        // 6: reset mid-frame discards it silently
        step(cw(8'hFB), 1'b1);
        words(3);
        rst = 1'b1;
        step(pw(8'h18), 1'b0);
        rst = 1'b0;
        cmp("t6_rst_good", good0, 32'd0);
        cmp("t6_rst_bad",  bad0, 32'd0);
        words(2);
        step(cw(8'hFB), 1'b1);
        words(8);
        expect_both(mk(1'b1, 3'd0, 16'd8), mk(1'b1, 3'd0, 16'd8));
        step(cw(8'hFD), 1'b1);
        step(cw(8'h07), 1'b1);
        cmp("t6_good", good0, 32'd1);
        cmp("t6_bad",  bad0, 32'd0);
        cmp("t6_len_held", {16'd0, len0}, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
